jzjpcc_fetch_unit: RTL and testbench
====================================

Name: jzjpcc_fetch_unit

Overview:
- Instruction fetch stage of the pipelined core; consumes the hazard unit's stall_fetch/stall_decode/flush_decode outputs and the redirect request.
- Owns the fetch PC, issues in-order requests to instruction memory, and buffers returned words in a small queue.
- Drives the IF/ID pipeline register (instruction, PC, valid) seen by decode; discards stale in-flight responses after a redirect.

Parameters:
- RESET_VECTOR, 32'h00000000, first fetch address after reset.
- QUEUE_DEPTH, 2, fetch queue entries and maximum in-flight plus queued requests (power of 2, ≥2).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_fetch  in  1  from hazard unit; no new requests issued.
- stall_decode  in  1  from hazard unit; IF/ID register holds.
- flush_decode  in  1  from hazard unit; redirect taken, IF/ID gets a bubble.
- pcCTTarget  in  32  redirect target, valid when flush_decode=1.
- imemReqValid  out  1  request valid.
- imemReqAddr  out  32  word-aligned request address.
- imemReqReady  in  1  memory accepts request this cycle.
- imemRespValid  in  1  response valid; in order, ≥1 cycle after acceptance.
- imemRespData  in  32  instruction word.
- instruction_decode  out  32  IF/ID instruction.
- pc_decode  out  32  IF/ID PC.
- valid_decode  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, reset_n=0): fetchPC=RESET_VECTOR, respPC=RESET_VECTOR, queue empty, inflight=0, dropCount=0, instruction_decode=32'h00000013 (NOP), pc_decode=0, valid_decode=0. imemReqValid=0 while reset_n=0. Reset mid-operation abandons all in-flight requests; memory must also be reset.
- redirect = flush_decode && !stall_decode. When flush_decode and stall_decode are both 1, the flush is ignored and IF/ID holds.
- Issue: imemReqValid = !stall_fetch && !redirect && (inflight + queueCount < QUEUE_DEPTH). imemReqAddr = fetchPC. On valid && ready: fetchPC += 4, inflight += 1. The address may change while unaccepted, for example after a redirect.
- Response with dropCount>0: word discarded; dropCount−1, inflight−1.
- Response with dropCount=0: push {respPC, imemRespData}; respPC += 4; inflight−1. Overflow is impossible by the credit rule; the bench asserts it never occurs.
- Redirect cycle:
  - Next state: fetchPC=pcCTTarget, respPC=pcCTTarget, queue cleared.
  - dropCount = inflight + issue − (response this cycle ? 1 : 0), where issue is 0 in this cycle.
  - Any response arriving this cycle is discarded.
  - IF/ID loads the bubble: NOP, valid_decode=0, pc_decode unchanged.
  - First fetch from the target is issued in the next cycle.
- IF/ID update, in priority order:
  - reset;
  - redirect → bubble;
  - stall_decode → hold;
  - queue nonempty → pop head into IF/ID, valid_decode=1;
  - else → bubble.
- No bypass: a response pushed at edge N reaches IF/ID at edge N+1 at the earliest.
- Push and pop in the same cycle are allowed, and queueCount is unchanged.
- stall_fetch blocks issue only. Responses continue to be accepted into the queue.
- Wrap-around: PC increments mod 2^32. Queue pointers are log2(QUEUE_DEPTH) bits and wrap naturally.

Optional Feature:
- Macro JZJPCC_FETCH_PERF_COUNTERS_EN.
- When defined, adds outputs perfRedirects[31:0] (+1 per redirect cycle) and perfBubbles[31:0] (+1 per cycle IF/ID loads a bubble outside reset). Both reset to 0 and wrap at 2^32.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, imemReqReady=1, 1-cycle memory → requests at 0x0,0x4,0x8…; first valid_decode=1 with pc_decode=0x0 two edges after the first response; consecutive PCs after that.
- imemReqReady=0 for 5 cycles → imemReqValid stays 1, imemReqAddr stays 0x0, fetchPC unchanged, IF/ID bubbles; afterwards the stream resumes at 0x0.
- Two requests in flight, flush_decode=1 with pcCTTarget=0x100 → both stale responses dropped, next IF/ID instruction has pc_decode=0x100, no stale PC ever reaches decode.
- flush_decode=1 and stall_decode=1 together → IF/ID holds, no redirect; next fetch address continues sequentially.
- stall_decode=1 for 4 cycles with responses arriving → queue fills to 2, imemReqValid=0 at full credit, IF/ID unchanged; after release, in-order PCs with no loss or duplication.
- reset_n asserted mid-stream → outputs immediately return to their reset values; after release, fetch restarts at RESET_VECTOR with inflight=0.

Source files
------------

// File: rtl/jzjpcc_fetch_unit.sv
// Instruction fetch stage: fetch PC, in-order imem requests, response queue and IF/ID register.
// Optional perf counters under JZJPCC_FETCH_PERF_COUNTERS_EN.
module jzjpcc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000,
    parameter int          QUEUE_DEPTH  = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall_fetch,
    input  logic        stall_decode,
    input  logic        flush_decode,
    input  logic [31:0] pcCTTarget,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemReqReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic [31:0] instruction_decode,
    output logic [31:0] pc_decode,
    output logic        valid_decode
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0] perfRedirects,
    output logic [31:0] perfBubbles
`endif
);
    localparam int          PTR_W = $clog2(QUEUE_DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] drop_count;
    logic [CNT_W-1:0] q_count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      q_pc    [QUEUE_DEPTH];
    logic [31:0]      q_instr [QUEUE_DEPTH];

    logic             redirect;
    logic             issue;
    logic             push;
    logic             pop;
    logic             bubble;
    logic [CNT_W:0]   credit_used;

    assign redirect    = flush_decode && !stall_decode;
    assign credit_used = {1'b0, inflight} + {1'b0, q_count};
    assign imemReqValid = reset_n && !stall_fetch && !redirect
                          && (credit_used < (CNT_W + 1)'(QUEUE_DEPTH));
    assign imemReqAddr = fetch_pc;
    assign issue       = imemReqValid && imemReqReady;
    // Responses still owed to a pre-redirect request are dropped via drop_count.
    assign push        = imemRespValid && !redirect && (drop_count == '0);
    assign pop         = !redirect && !stall_decode && (q_count != '0);
    assign bubble      = redirect || (!stall_decode && (q_count == '0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc   <= RESET_VECTOR;
            resp_pc    <= RESET_VECTOR;
            inflight   <= '0;
            drop_count <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= pcCTTarget;
                resp_pc  <= pcCTTarget;
            end else begin
                if (issue) fetch_pc <= fetch_pc + 32'd4;
                if (push)  resp_pc  <= resp_pc + 32'd4;
            end
            inflight <= inflight + CNT_W'(issue) - CNT_W'(imemRespValid);
            if (redirect)
                drop_count <= inflight - CNT_W'(imemRespValid);
            else if (imemRespValid && (drop_count != '0))
                drop_count <= drop_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else if (redirect) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            q_count <= q_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            q_pc[wr_ptr]    <= resp_pc;
            q_instr[wr_ptr] <= imemRespData;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instruction_decode <= NOP;
            pc_decode          <= 32'h0;
            valid_decode       <= 1'b0;
        end else if (bubble) begin
            instruction_decode <= NOP;
            valid_decode       <= 1'b0;
        end else if (pop) begin
            instruction_decode <= q_instr[rd_ptr];
            pc_decode          <= q_pc[rd_ptr];
            valid_decode       <= 1'b1;
        end
    end

`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perfRedirects <= 32'h0;
            perfBubbles   <= 32'h0;
        end else begin
            if (redirect) perfRedirects <= perfRedirects + 32'd1;
            if (bubble)   perfBubbles   <= perfBubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jzjpcc_fetch_unit.sv
// Bench for jzjpcc_fetch_unit: epoch-tagged memory/queue model checked every cycle plus literal pins.
module tb_jzjpcc_fetch_unit;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall_fetch, stall_decode, flush_decode;
    logic [31:0] pcCTTarget;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic [31:0] instruction_decode, pc_decode;
    logic        valid_decode;
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
    logic [31:0] perfRedirects, perfBubbles;
`endif

    jzjpcc_fetch_unit #(.RESET_VECTOR(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode), .flush_decode(flush_decode),
        .pcCTTarget(pcCTTarget),
        .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
        .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .instruction_decode(instruction_decode), .pc_decode(pc_decode), .valid_decode(valid_decode)
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
        , .perfRedirects(perfRedirects), .perfBubbles(perfBubbles)
`endif
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int due; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        pend[$];
    ent_t        mq[$];
    logic [31:0] seen[$];
    logic [31:0] m_fpc, m_instr, m_pc, m_redir, m_bub;
    logic        m_valid;
    int          m_epoch = 0;
    int          cyc = 0;
    int          lat = 1;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        imemRespValid = 1'b0;
        imemRespData = 32'h0;
        pend.delete();
        mq.delete();
        m_epoch++;
        m_fpc = 32'h0; m_instr = NOP; m_pc = 32'h0; m_valid = 1'b0;
        m_redir = 32'h0; m_bub = 32'h0;
        #1;
        chk("rst_req_valid", 32'(imemReqValid), 32'h0);
        chk("rst_valid_decode", 32'(valid_decode), 32'h0);
        chk("rst_instr", instruction_decode, NOP);
        chk("rst_pc", pc_decode, 32'h0);
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
        chk("rst_perf_redir", perfRedirects, 32'h0);
        chk("rst_perf_bub", perfBubbles, 32'h0);
`endif
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // One clock of stimulus, memory response, model step and full output compare.
    task automatic cycle();
        logic redirect, exp_req, issue, rv;
        req_t p;
        ent_t e;
        @(negedge clock);
        cyc++;
        rv = (pend.size() > 0) && (pend[0].due <= cyc);
        imemRespValid = rv;
        imemRespData  = rv ? ~pend[0].addr : 32'h0;
        #1;
        redirect = flush_decode && !stall_decode;
        exp_req  = !stall_fetch && !redirect && (pend.size() + mq.size() < DEPTH);
        chk("req_valid", 32'(imemReqValid), 32'(exp_req));
        if (exp_req) chk("req_addr", imemReqAddr, m_fpc);
        issue = exp_req && imemReqReady;
        if (imemReqValid && imemReqReady)
            pend.push_back('{addr: imemReqAddr, due: cyc + lat, epoch: m_epoch});
        if (redirect) begin
            m_instr = NOP; m_valid = 1'b0; m_redir++; m_bub++;
        end else if (!stall_decode) begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_instr = e.instr; m_pc = e.pc; m_valid = 1'b1;
            end else begin
                m_instr = NOP; m_valid = 1'b0; m_bub++;
            end
        end
        if (rv) begin
            p = pend.pop_front();
            if (!redirect && p.epoch == m_epoch) mq.push_back('{pc: p.addr, instr: ~p.addr});
        end
        if (mq.size() > DEPTH) chk("queue_overflow", mq.size(), DEPTH);
        if (redirect) begin
            mq.delete();
            m_epoch++;
            m_fpc = pcCTTarget;
        end else if (issue) begin
            m_fpc = m_fpc + 32'd4;
        end
        @(posedge clock);
        #1;
        chk("valid_decode", 32'(valid_decode), 32'(m_valid));
        chk("instruction_decode", instruction_decode, m_instr);
        chk("pc_decode", pc_decode, m_pc);
`ifdef JZJPCC_FETCH_PERF_COUNTERS_EN
        chk("perf_redirects", perfRedirects, m_redir);
        chk("perf_bubbles", perfBubbles, m_bub);
`endif
        if (valid_decode) seen.push_back(pc_decode);
    endtask

    initial begin
        reset_n = 1'b1;
        stall_fetch = 1'b0; stall_decode = 1'b0; flush_decode = 1'b0;
        pcCTTarget = 32'h0; imemReqReady = 1'b1;
        imemRespValid = 1'b0; imemRespData = 32'h0;
        do_reset();

        // Straight-line stream from reset with a 1-cycle memory.
        lat = 1;
        seen.delete();
        repeat (14) cycle();
        chk("stream_count", 32'(seen.size() >= 3), 32'h1);
        if (seen.size() >= 3) begin
            chk("stream_pc0", seen[0], 32'h0);
            chk("stream_pc1", seen[1], 32'h4);
            chk("stream_pc2", seen[2], 32'h8);
        end

        // Memory not ready for 5 cycles right after reset.
        do_reset();
        seen.delete();
        imemReqReady = 1'b0;
        repeat (5) cycle();
        chk("notready_valid", 32'(imemReqValid), 32'h1);
        chk("notready_addr", imemReqAddr, 32'h0);
        chk("notready_no_decode", seen.size(), 32'h0);
        imemReqReady = 1'b1;
        repeat (8) cycle();
        chk("resume_count", 32'(seen.size() >= 1), 32'h1);
        if (seen.size() >= 1) chk("resume_pc0", seen[0], 32'h0);

        // Redirect with two requests outstanding on a slower memory.
        lat = 3;
        for (int i = 0; i < 20 && pend.size() != 2; i++) cycle();
        chk("two_inflight", pend.size(), 32'h2);
        seen.delete();
        flush_decode = 1'b1; pcCTTarget = 32'h100;
        cycle();
        flush_decode = 1'b0;
        repeat (16) cycle();
        chk("flush_seen", 32'(seen.size() >= 2), 32'h1);
        if (seen.size() >= 1) chk("flush_first_pc", seen[0], 32'h100);
        foreach (seen[i]) chk("no_stale_pc", 32'(seen[i] >= 32'h100 && seen[i] < 32'h140), 32'h1);

        // Flush while decode is stalled is ignored.
        lat = 1;
        stall_decode = 1'b1; flush_decode = 1'b1; pcCTTarget = 32'h200;
        cycle();
        stall_decode = 1'b0; flush_decode = 1'b0;
        repeat (4) cycle();

        // Decode stalled long enough for the queue to take all the credit.
        stall_decode = 1'b1;
        repeat (4) cycle();
        chk("full_credit_valid", 32'(imemReqValid), 32'h0);
        seen.delete();
        stall_decode = 1'b0;
        repeat (10) cycle();
        chk("release_seen", 32'(seen.size() >= 4), 32'h1);
        if (seen.size() >= 4)
            for (int i = 1; i < 4; i++) chk("release_step", seen[i] - seen[i-1], 32'h4);

        // PC wrap-around at the top of the address space.
        seen.delete();
        flush_decode = 1'b1; pcCTTarget = 32'hFFFF_FFF8;
        cycle();
        flush_decode = 1'b0;
        repeat (14) cycle();
        chk("wrap_seen", 32'(seen.size() >= 3), 32'h1);
        if (seen.size() >= 3) begin
            chk("wrap_pc0", seen[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", seen[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", seen[2], 32'h0000_0000);
        end

        // Reset in the middle of a stream, then restart from the reset vector.
        repeat (3) cycle();
        do_reset();
        chk("restart_addr", imemReqAddr, 32'h0);
        seen.delete();
        repeat (10) cycle();
        chk("restart_seen", 32'(seen.size() >= 1), 32'h1);
        if (seen.size() >= 1) chk("restart_pc0", seen[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
